// File: rtl/mem_stage_sram_pkg.sv
// Shared widths, memory map constant and FSM encoding for the memory stage.
package mem_stage_sram_pkg;

    localparam int REGISTER_LEN    = 32;
    localparam int REG_ADDRESS_LEN = 4;

    // Byte address where the SRAM window starts in the CPU address map.
    localparam logic [REGISTER_LEN-1:0] MEM_BASE_ADDR = 32'd1024;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_sram_reg.sv
// Write-back pipeline register. While frozen it inserts a bubble so a held
// instruction is written back only once.
import mem_stage_sram_pkg::*;

module mem_stage_reg (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic [REGISTER_LEN-1:0]    alu_res_in,
    input  logic [REGISTER_LEN-1:0]    mem_rdata,
    input  logic [REG_ADDRESS_LEN-1:0] dest_in,
    output logic                       wb_en_out,
    output logic                       mem_r_en_out,
    output logic [REGISTER_LEN-1:0]    alu_res_out,
    output logic [REGISTER_LEN-1:0]    mem_data_out,
    output logic [REG_ADDRESS_LEN-1:0] dest_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_res_out  <= '0;
            mem_data_out <= '0;
            dest_out     <= '0;
        end else if (freeze) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
        end else begin
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            alu_res_out  <= alu_res_in;
            dest_out     <= dest_in;
            // A write wins over a simultaneous read, so only pure reads load data.
            if (mem_r_en_in && !mem_w_en_in)
                mem_data_out <= mem_rdata;
        end
    end

endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage: drives a fixed-latency single-port SRAM, freezes upstream
// while an access is in flight and feeds the write-back register.
import mem_stage_sram_pkg::*;

module mem_stage_sram #(
    parameter int WAIT_STATES = 2,
    parameter int SRAM_ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic [REGISTER_LEN-1:0]    alu_res_in,
    input  logic [REGISTER_LEN-1:0]    val_Rm_in,
    input  logic [REG_ADDRESS_LEN-1:0] dest_in,
    output logic                       freeze,
    output logic                       wb_en_hazard,
    output logic [REG_ADDRESS_LEN-1:0] dest_hazard,
    output logic [SRAM_ADDR_W-1:0]     sram_addr,
    output logic [REGISTER_LEN-1:0]    sram_wdata,
    input  logic [REGISTER_LEN-1:0]    sram_rdata,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       wb_en_out,
    output logic                       mem_r_en_out,
    output logic [REGISTER_LEN-1:0]    alu_res_out,
    output logic [REGISTER_LEN-1:0]    mem_data_out,
    output logic [REG_ADDRESS_LEN-1:0] dest_out,
    output mem_state_t                 dbg_state,
    output logic [2:0]                 dbg_cnt
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    // Stall protocol: the EX register presents an op and holds it unchanged
    // while freeze is high; the cycle freeze is low is the one where this
    // stage accepts the op, so the next op may appear in the very next cycle.
    mem_state_t state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       req, active, last, freeze_c;

    assign req = mem_r_en_in | mem_w_en_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MEM_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        freeze_c   = 1'b0;
        active     = 1'b0;
        last       = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (req) begin
                    freeze_c   = 1'b1;
                    active     = 1'b1;
                    state_next = MEM_ACCESS;
                    cnt_next   = 3'd1;
                end
            end
            MEM_ACCESS: begin
                active = 1'b1;
                if (cnt == WS) begin
                    last       = 1'b1;
                    state_next = MEM_IDLE;
                    cnt_next   = 3'd0;
                end else begin
                    freeze_c = 1'b1;
                    cnt_next = cnt + 3'd1;
                end
            end
            default: begin
                state_next = MEM_IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // Reset gates the combinational outputs so an abandoned access drops its strobes at once.
    assign freeze    = rst & freeze_c;
    assign sram_we_n = ~(rst & active & mem_w_en_in & ~last);
    assign sram_oe_n = ~(rst & active & mem_r_en_in & ~mem_w_en_in);

    assign sram_addr    = SRAM_ADDR_W'((alu_res_in - MEM_BASE_ADDR) >> 2);
    assign sram_wdata   = val_Rm_in;
    assign wb_en_hazard = wb_en_in;
    assign dest_hazard  = dest_in;
    assign dbg_state    = state;
    assign dbg_cnt      = cnt;

    mem_stage_reg u_reg (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .alu_res_in   (alu_res_in),
        .mem_rdata    (sram_rdata),
        .dest_in      (dest_in),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_res_out  (alu_res_out),
        .mem_data_out (mem_data_out),
        .dest_out     (dest_out)
    );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: ALU vector table plus hand-written
// load/store/reset/write-priority sequences against a small SRAM model.
import mem_stage_sram_pkg::*;

module tb_mem_stage_sram;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, val_Rm_in;
    logic [3:0]  dest_in;

    // Instance 0: WAIT_STATES = 2, attached to the SRAM model
    logic        freeze, wb_en_hazard, sram_we_n, sram_oe_n, wb_en_out, mem_r_en_out;
    logic [3:0]  dest_hazard, dest_out;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata, alu_res_out, mem_data_out;
    mem_state_t  dbg_state;
    logic [2:0]  dbg_cnt;

    // Instance 1: WAIT_STATES = 1, read data tied to a marker value
    logic        freeze_1, wb_en_hazard_1, sram_we_n_1, sram_oe_n_1, wb_en_out_1, mem_r_en_out_1;
    logic [3:0]  dest_hazard_1, dest_out_1;
    logic [15:0] sram_addr_1;
    logic [31:0] sram_wdata_1, alu_res_out_1, mem_data_out_1;
    logic [31:0] sram_rdata_1 = 32'hCAFE_F00D;
    mem_state_t  dbg_state_1;
    logic [2:0]  dbg_cnt_1;

    mem_stage_sram #(.WAIT_STATES(2), .SRAM_ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in),
        .dest_in(dest_in), .freeze(freeze), .wb_en_hazard(wb_en_hazard),
        .dest_hazard(dest_hazard), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
        .mem_data_out(mem_data_out), .dest_out(dest_out), .dbg_state(dbg_state),
        .dbg_cnt(dbg_cnt)
    );

    mem_stage_sram #(.WAIT_STATES(1), .SRAM_ADDR_W(16)) dut1 (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in),
        .dest_in(dest_in), .freeze(freeze_1), .wb_en_hazard(wb_en_hazard_1),
        .dest_hazard(dest_hazard_1), .sram_addr(sram_addr_1), .sram_wdata(sram_wdata_1),
        .sram_rdata(sram_rdata_1), .sram_we_n(sram_we_n_1), .sram_oe_n(sram_oe_n_1),
        .wb_en_out(wb_en_out_1), .mem_r_en_out(mem_r_en_out_1), .alu_res_out(alu_res_out_1),
        .mem_data_out(mem_data_out_1), .dest_out(dest_out_1), .dbg_state(dbg_state_1),
        .dbg_cnt(dbg_cnt_1)
    );

    // SRAM model: word 1 preloaded with 0xDEADBEEF until overwritten
    bit [31:0]  sram_mem [256];
    bit [255:0] written;
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr[7:0]] <= sram_wdata;
            written[sram_addr[7:0]]  <= 1'b1;
        end
    end
    assign sram_rdata = sram_oe_n ? 32'h0 :
                        (sram_addr[7:0] == 8'd1 && !written[1]) ? 32'hDEAD_BEEF :
                        sram_mem[sram_addr[7:0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one memory op whose inputs the caller has just driven (posedge+1).
    // Returns at posedge+1 after the capturing edge, having checked the result.
    task automatic mem_op(input string tag, input int which, input int ws, input logic r,
                          input logic w, input logic wb, input logic [31:0] exp_data,
                          input logic [15:0] exp_addr);
        logic fz, wen, oen, wbo, mro;
        logic [31:0] st;
        for (int i = 0; i <= ws; i++) begin
            @(negedge clk);
            fz  = (which == 1) ? freeze_1 : freeze;
            wen = (which == 1) ? sram_we_n_1 : sram_we_n;
            oen = (which == 1) ? sram_oe_n_1 : sram_oe_n;
            wbo = (which == 1) ? wb_en_out_1 : wb_en_out;
            mro = (which == 1) ? mem_r_en_out_1 : mem_r_en_out;
            st  = (which == 1) ? 32'(dbg_state_1) : 32'(dbg_state);
            check($sformatf("%s c%0d freeze", tag, i), 32'(fz), 32'(i < ws));
            check($sformatf("%s c%0d we_n", tag, i), 32'(wen), 32'(!(w && i < ws)));
            check($sformatf("%s c%0d oe_n", tag, i), 32'(oen), 32'(!(r && !w)));
            check($sformatf("%s c%0d state", tag, i), st,
                  (i == 0) ? 32'(MEM_IDLE) : 32'(MEM_ACCESS));
            if (i == 0) begin
                check($sformatf("%s addr", tag),
                      32'((which == 1) ? sram_addr_1 : sram_addr), 32'(exp_addr));
                check($sformatf("%s wdata", tag),
                      (which == 1) ? sram_wdata_1 : sram_wdata, val_Rm_in);
            end else begin
                check($sformatf("%s c%0d bubble wb_en_out", tag, i), 32'(wbo), 32'd0);
                check($sformatf("%s c%0d bubble mem_r_en_out", tag, i), 32'(mro), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        check({tag, " wb_en_out"}, 32'((which == 1) ? wb_en_out_1 : wb_en_out), 32'(wb));
        check({tag, " mem_r_en_out"}, 32'((which == 1) ? mem_r_en_out_1 : mem_r_en_out), 32'(r));
        check({tag, " alu_res_out"}, (which == 1) ? alu_res_out_1 : alu_res_out, alu_res_in);
        check({tag, " dest_out"}, 32'((which == 1) ? dest_out_1 : dest_out), 32'(dest_in));
        check({tag, " mem_data_out"}, (which == 1) ? mem_data_out_1 : mem_data_out, exp_data);
    endtask

    typedef struct {
        logic        wb;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic [15:0] exp_addr;
    } alu_vec_t;

    alu_vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_00AB, 4'd5,  16'hFF2A};
        vecs[1] = '{1'b0, 32'd1024,      4'd0,  16'h0000};
        vecs[2] = '{1'b1, 32'd1027,      4'd15, 16'h0000};
        vecs[3] = '{1'b1, 32'd1028,      4'd7,  16'h0001};
        vecs[4] = '{1'b1, 32'h0004_0400, 4'd9,  16'h0000};
        vecs[5] = '{1'b1, 32'h0004_03FC, 4'd1,  16'hFFFF};
        vecs[6] = '{1'b0, 32'h1234_5678, 4'd2,  16'h149E};

        // Reset held with a read requested
        rst = 1'b0;
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
        alu_res_in = 32'd1028; val_Rm_in = 32'h0; dest_in = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst freeze", 32'(freeze), 32'd0);
        check("rst we_n", 32'(sram_we_n), 32'd1);
        check("rst oe_n", 32'(sram_oe_n), 32'd1);
        check("rst state", 32'(dbg_state), 32'(MEM_IDLE));
        check("rst cnt", 32'(dbg_cnt), 32'd0);
        check("rst wb_en_out", 32'(wb_en_out), 32'd0);
        check("rst mem_r_en_out", 32'(mem_r_en_out), 32'd0);
        check("rst alu_res_out", alu_res_out, 32'd0);
        check("rst mem_data_out", mem_data_out, 32'd0);
        check("rst dest_out", 32'(dest_out), 32'd0);
        mem_r_en_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU pass-through and address translation
        for (int v = 0; v < 7; v++) begin
            wb_en_in = vecs[v].wb; alu_res_in = vecs[v].alu; dest_in = vecs[v].dest;
            @(negedge clk);
            check($sformatf("alu%0d freeze", v), 32'(freeze), 32'd0);
            check($sformatf("alu%0d sram_addr", v), 32'(sram_addr), 32'(vecs[v].exp_addr));
            check($sformatf("alu%0d wb_en_hazard", v), 32'(wb_en_hazard), 32'(vecs[v].wb));
            check($sformatf("alu%0d dest_hazard", v), 32'(dest_hazard), 32'(vecs[v].dest));
            @(posedge clk);
            #1;
            check($sformatf("alu%0d wb_en_out", v), 32'(wb_en_out), 32'(vecs[v].wb));
            check($sformatf("alu%0d alu_res_out", v), alu_res_out, vecs[v].alu);
            check($sformatf("alu%0d dest_out", v), 32'(dest_out), 32'(vecs[v].dest));
            check($sformatf("alu%0d mem_r_en_out", v), 32'(mem_r_en_out), 32'd0);
            check($sformatf("alu%0d mem_data_out", v), mem_data_out, 32'd0);
        end

        // Load, then store, then load back with no idle cycles between them
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
        alu_res_in = 32'd1028; dest_in = 4'd3; val_Rm_in = 32'h0;
        mem_op("load1", 0, 2, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 16'd1);
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
        alu_res_in = 32'd1032; dest_in = 4'd6; val_Rm_in = 32'h1234_5678;
        mem_op("store", 0, 2, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 16'd2);
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
        alu_res_in = 32'd1032; dest_in = 4'd8; val_Rm_in = 32'h0;
        mem_op("load2", 0, 2, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 16'd2);

        // Reset pulsed during the second cycle of a load
        alu_res_in = 32'd1028; dest_in = 4'd2;
        @(negedge clk);
        check("rload c0 freeze", 32'(freeze), 32'd1);
        @(posedge clk);
        #1;
        check("rload c1 state", 32'(dbg_state), 32'(MEM_ACCESS));
        rst = 1'b0;
        #1;
        check("rload freeze", 32'(freeze), 32'd0);
        check("rload we_n", 32'(sram_we_n), 32'd1);
        check("rload oe_n", 32'(sram_oe_n), 32'd1);
        check("rload state", 32'(dbg_state), 32'(MEM_IDLE));
        check("rload cnt", 32'(dbg_cnt), 32'd0);
        check("rload mem_data_out", mem_data_out, 32'd0);
        check("rload wb_en_out", 32'(wb_en_out), 32'd0);
        check("rload dest_out", 32'(dest_out), 32'd0);
        mem_r_en_in = 1'b0; wb_en_in = 1'b1; alu_res_in = 32'h55; dest_in = 4'd4;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-rst freeze", 32'(freeze), 32'd0);
        check("post-rst state", 32'(dbg_state), 32'(MEM_IDLE));
        @(posedge clk);
        #1;
        check("post-rst wb_en_out", 32'(wb_en_out), 32'd1);
        check("post-rst alu_res_out", alu_res_out, 32'h55);
        check("post-rst dest_out", 32'(dest_out), 32'd4);
        check("post-rst mem_data_out", mem_data_out, 32'd0);

        // Both enables high on the WAIT_STATES=1 instance: treated as a write
        rst = 1'b0;
        wb_en_in = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("both pre state", 32'(dbg_state_1), 32'(MEM_IDLE));
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
        alu_res_in = 32'd1036; dest_in = 4'd10; val_Rm_in = 32'hA5A5_A5A5;
        mem_op("both", 1, 1, 1'b1, 1'b1, 1'b1, 32'h0, 16'd3);
        mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; wb_en_in = 1'b0;
        @(negedge clk);
        check("both after freeze", 32'(freeze_1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage of the five-stage ARM pipeline. It sits directly downstream of the execute-stage pipeline register and consumes its ALU result, store data, destination and control bits. Loads and stores go through an external single-port SRAM with a fixed number of wait states. While an access is in flight the stage freezes the upstream pipeline; the result is handed to write-back through its own pipeline register.

## Interface
Parameters:
- WAIT_STATES, 2: extra cycles an SRAM access needs beyond the request cycle; legal range 1..7.
- SRAM_ADDR_W, 16: SRAM word-address width.

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from the EX register.
- alu_res_in  in  `REGISTER_LEN  byte address for memory ops; write-back value for ALU ops.
- val_Rm_in  in  `REGISTER_LEN  store data.
- dest_in  in  `REG_ADDRESS_LEN  destination register.
- freeze  out  1  high means upstream stages and the PC hold their state.
- wb_en_hazard, dest_hazard  out  1 / `REG_ADDRESS_LEN  combinational copies of wb_en_in and dest_in for the hazard unit.
- sram_addr  out  SRAM_ADDR_W  word address.
- sram_wdata  out  `REGISTER_LEN  write data; equals val_Rm_in.
- sram_rdata  in  `REGISTER_LEN  read data; valid in the last access cycle.
- sram_we_n, sram_oe_n  out  1 each  active-low write and output enables.
- wb_en_out, mem_r_en_out  out  1 each  registered outputs to write-back.
- alu_res_out, mem_data_out  out  `REGISTER_LEN each  registered outputs to write-back.
- dest_out  out  `REG_ADDRESS_LEN  registered output to write-back.

## Operation
- Address translation: sram_addr = (alu_res_in − `MEM_BASE_ADDR)[SRAM_ADDR_W+1:2]. The low two bits are ignored and there is no range check; the address truncates.
- FSM states:
  - IDLE: if (mem_r_en_in | mem_w_en_in), freeze = 1, strobes assert, and the next state is ACCESS with cnt = 1.
  - ACCESS: if cnt == WAIT_STATES, freeze = 0 and the next state is IDLE. Otherwise cnt increments and freeze stays 1.
- Strobes:
  - Write: sram_we_n = 0 in every access cycle except the last. This gives a rising edge at the end of the access.
  - Read: sram_oe_n = 0 in every access cycle.
  - If mem_r_en_in and mem_w_en_in are both high, the access is a write. sram_oe_n stays 1, mem_data_out is unchanged, and mem_r_en_out is still forwarded.
- Non-memory ops (both enables low): no FSM activity, freeze = 0, and the register captures in one cycle.
- Pipeline register (mem_stage_reg):
  - freeze = 0: it captures all fields; mem_data_out ← sram_rdata only for reads.
  - freeze = 1: it loads a bubble, i.e. wb_en_out = 0 and mem_r_en_out = 0, with the other fields held. This prevents repeated write-back.
- Hazard outputs are pure wires with no gating.
- While rst is low:
  - freeze = 0, sram_we_n = sram_oe_n = 1.
  - State is IDLE and cnt = 0.
  - All registered outputs are 0.

## Timing
- A memory op occupies the stage for WAIT_STATES+1 cycles, with freeze high for exactly WAIT_STATES of them.
  - With the default WAIT_STATES = 2: 3 cycles, freeze high for 2.
- freeze is combinational from state, cnt and the enables. It asserts in the same cycle the request appears.
- Read data is captured at the rising edge that ends the last ACCESS cycle. It is visible on mem_data_out in the next cycle.
- Back-to-back memory ops: a new request can be seen in IDLE in the cycle right after completion, with no dead cycle.
- Reset asserted mid-access:
  - The access is abandoned immediately (asynchronously) and strobes deassert.
  - No partial result reaches the register.
  - After release, the stage starts in IDLE.

## Structure
- Defines.v (shared) gains `MEM_BASE_ADDR (1024) and the 1-bit state encodings `MEM_IDLE / `MEM_ACCESS. It also supplies the existing `REGISTER_LEN and `REG_ADDRESS_LEN.
- Sub-module mem_stage_reg holds the write-back pipeline register, including the freeze/bubble input and asynchronous active-low reset.
- The top level contains the FSM, cnt (3 bits), address translation and strobe logic.

## Test plan
- Reset: hold rst = 0 with mem_r_en_in = 1 → freeze = 0, sram_we_n = sram_oe_n = 1, all registered outputs 0.
- ALU pass-through: wb_en_in = 1, alu_res_in = 0x0000_00AB, dest_in = 5 → next cycle wb_en_out = 1, alu_res_out = 0xAB, dest_out = 5, freeze never asserted.
- Load: alu_res_in = 1028, model returns 0xDEAD_BEEF → sram_addr = 1, freeze high for 2 cycles, mem_data_out = 0xDEADBEEF after cycle 3, wb_en_out = 0 during the frozen cycles.
- Store then load to the same address: store 0x1234_5678 at 1032 (sram_we_n low for 2 cycles, then high), then load 1032 → mem_data_out = 0x12345678, no idle gap between the two accesses.
- Reset pulsed in the second cycle of a load → strobes deassert within that cycle, no capture, FSM in IDLE after release, a following ALU op completes in 1 cycle.
- Both enables high, WAIT_STATES = 1 → treated as a write, sram_oe_n stays 1, freeze high for 1 cycle.
